serializador_piso: RTL and testbench

- Parallel-in, serial-out shift register; the transmit-side counterpart of the team's serial-in/parallel-out ShiftRegister.
- Captures a LARGURA-bit word on a load strobe and presents it one bit per enabled clock on bitSaida.
- bitSaida is intended to drive the ShiftRegister novoBit input directly, so a word crosses a 1-bit link and is rebuilt in parallel at the far end.

---
 rtl/serializador_piso.sv | 104 ++++++++++
 tb/tb_serializador_piso.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_piso.sv
// =============================================================================
// Module   : serializador_piso
// Purpose  : Parallel-in, serial-out shift register feeding a 1-bit link.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module serializador_piso #(
    parameter int   LARGURA      = 8,
    parameter logic MSB_PRIMEIRO = 1'b1,
    parameter logic NIVEL_OCIOSO = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       carregar,
    input  logic [LARGURA-1:0]         dado,
    input  logic                       habilitar,
    output logic                       bitSaida,
    output logic                       ocupado,
    output logic                       concluido,
    output logic [$clog2(LARGURA)-1:0] contagem
);

    localparam int                c_cw     = $clog2(LARGURA);
    localparam logic [c_cw-1:0]   c_ultimo = c_cw'(LARGURA - 1);

    localparam logic [0:0] c_ocioso       = 1'b0;
    localparam logic [0:0] c_transmitindo = 1'b1;

    logic [0:0]         r_estado;
    logic [LARGURA-1:0] r_registro;

    logic               w_primeiro_bit;
    logic               w_proximo_bit;
    logic [LARGURA-1:0] w_deslocado;

    // The register always shifts toward the output end, so the next bit to
    // present sits right behind the current one.
    generate
        if (MSB_PRIMEIRO) begin : g_msb_primeiro
            assign w_primeiro_bit = dado[LARGURA-1];
            assign w_proximo_bit  = r_registro[LARGURA-2];
            assign w_deslocado    = {r_registro[LARGURA-2:0], 1'b0};
        end else begin : g_lsb_primeiro
            assign w_primeiro_bit = dado[0];
            assign w_proximo_bit  = r_registro[1];
            assign w_deslocado    = {1'b0, r_registro[LARGURA-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= c_ocioso;
            r_registro <= '0;
            bitSaida   <= NIVEL_OCIOSO;
            ocupado    <= 1'b0;
            concluido  <= 1'b0;
            contagem   <= '0;
        end else begin
            concluido <= 1'b0;
            case (r_estado)
                c_ocioso: begin
                    bitSaida <= NIVEL_OCIOSO;
                    if (carregar) begin
                        r_estado   <= c_transmitindo;
                        r_registro <= dado;
                        bitSaida   <= w_primeiro_bit;
                        ocupado    <= 1'b1;
                        contagem   <= '0;
                    end
                end
                c_transmitindo: begin
                    if (habilitar) begin
                        if (contagem == c_ultimo) begin
                            concluido <= 1'b1;
                            contagem  <= '0;
                            // A load on the final edge chains the next word
                            // without an idle gap.
                            if (carregar) begin
                                r_registro <= dado;
                                bitSaida   <= w_primeiro_bit;
                            end else begin
                                r_estado   <= c_ocioso;
                                r_registro <= '0;
                                bitSaida   <= NIVEL_OCIOSO;
                                ocupado    <= 1'b0;
                            end
                        end else begin
                            r_registro <= w_deslocado;
                            bitSaida   <= w_proximo_bit;
                            contagem   <= contagem + 1'b1;
                        end
                    end
                end
                default: begin
                    r_estado <= c_ocioso;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serializador_piso.sv
// =============================================================================
// Module   : tb_serializador_piso
// Purpose  : Directed self-checking bench for serializador_piso.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_serializador_piso;

    logic       clock;
    logic       reset;
    logic       carregar;
    logic [7:0] dado;
    logic       habilitar;

    logic       bit_msb, ocupado_msb, concluido_msb;
    logic [2:0] contagem_msb;
    logic       bit_lsb, ocupado_lsb, concluido_lsb;
    logic [2:0] contagem_lsb;

    logic [7:0] rx;

    int passed = 0;
    int total  = 0;

    serializador_piso #(.LARGURA(8), .MSB_PRIMEIRO(1'b1), .NIVEL_OCIOSO(1'b0)) dut_msb (
        .clock     (clock),
        .reset     (reset),
        .carregar  (carregar),
        .dado      (dado),
        .habilitar (habilitar),
        .bitSaida  (bit_msb),
        .ocupado   (ocupado_msb),
        .concluido (concluido_msb),
        .contagem  (contagem_msb)
    );

    serializador_piso #(.LARGURA(8), .MSB_PRIMEIRO(1'b0), .NIVEL_OCIOSO(1'b0)) dut_lsb (
        .clock     (clock),
        .reset     (reset),
        .carregar  (carregar),
        .dado      (dado),
        .habilitar (habilitar),
        .bitSaida  (bit_lsb),
        .ocupado   (ocupado_lsb),
        .concluido (concluido_lsb),
        .contagem  (contagem_lsb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receiver model: MSB-first shift register sampling on every enabled edge.
    always @(posedge clock) begin
        if (habilitar) rx <= {rx[6:0], bit_msb};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        carregar  = 1'b1;
        dado      = w;
        habilitar = 1'b1;
        step();
        carregar = 1'b0;
        repeat (8) step();
        check("loopback_rx", 32'(rx), 32'(w));
        check("loopback_done", 32'(concluido_msb), 32'd1);
        step();
    endtask

    initial begin
        logic [7:0] exp_w;
        int         idx;
        int         cyc;
        int         pulses;

        reset     = 1'b1;
        carregar  = 1'b0;
        dado      = 8'h00;
        habilitar = 1'b0;
        rx        = 8'h00;

        repeat (3) step();
        check("reset_bit", 32'(bit_msb), 32'd0);
        check("reset_busy", 32'(ocupado_msb), 32'd0);
        check("reset_cnt", 32'(contagem_msb), 32'd0);
        reset = 1'b0;

        // Idle hold with no load
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_bit", 32'(bit_msb), 32'd0);
            check("idle_busy", 32'(ocupado_msb), 32'd0);
            check("idle_done", 32'(concluido_msb), 32'd0);
        end

        // Basic MSB-first frame 10110010
        exp_w     = 8'b1011_0010;
        carregar  = 1'b1;
        dado      = exp_w;
        habilitar = 1'b1;
        step();
        carregar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("basic_bit", 32'(bit_msb), 32'(exp_w[7-i]));
            check("basic_cnt", 32'(contagem_msb), 32'(i));
            check("basic_busy", 32'(ocupado_msb), 32'd1);
            check("basic_nodone", 32'(concluido_msb), 32'd0);
            step();
        end
        check("basic_done", 32'(concluido_msb), 32'd1);
        check("basic_busy_fall", 32'(ocupado_msb), 32'd0);
        check("basic_idle_bit", 32'(bit_msb), 32'd0);
        check("basic_cnt_wrap", 32'(contagem_msb), 32'd0);
        step();
        check("basic_done_1cyc", 32'(concluido_msb), 32'd0);

        // Loopback into receiver model
        send_word(8'hA5);
        send_word(8'h00);
        send_word(8'hFF);
        send_word(8'h01);

        // Stall pattern 1,0,0,1,... with an ignored mid-frame load of FF
        exp_w     = 8'hC3;
        carregar  = 1'b1;
        dado      = exp_w;
        habilitar = 1'b0;
        step();
        carregar = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 100) begin
            habilitar = (cyc % 3 == 0);
            carregar  = (cyc == 4);
            dado      = (cyc == 4) ? 8'hFF : exp_w;
            check("stall_bit", 32'(bit_msb), 32'(exp_w[7-idx]));
            step();
            if (habilitar) idx++;
            cyc++;
        end
        carregar  = 1'b0;
        habilitar = 1'b0;
        check("stall_finished", 32'(idx), 32'd8);
        check("stall_rx", 32'(rx), 32'hC3);
        check("stall_done", 32'(concluido_msb), 32'd1);
        check("stall_busy", 32'(ocupado_msb), 32'd0);
        step();

        // Back-to-back 0F then 5A
        carregar  = 1'b1;
        dado      = 8'h0F;
        habilitar = 1'b1;
        step();
        carregar = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 7; i++) begin
            check("b2b_first_bit", 32'(bit_msb), 32'(i >= 4));
            step();
            if (concluido_msb) pulses++;
        end
        check("b2b_last_bit", 32'(bit_msb), 32'd1);
        carregar = 1'b1;
        dado     = 8'h5A;
        step();
        carregar = 1'b0;
        check("b2b_done", 32'(concluido_msb), 32'd1);
        check("b2b_busy_held", 32'(ocupado_msb), 32'd1);
        check("b2b_cnt", 32'(contagem_msb), 32'd0);
        exp_w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (concluido_msb) pulses++;
            check("b2b_second_bit", 32'(bit_msb), 32'(exp_w[7-i]));
            check("b2b_second_busy", 32'(ocupado_msb), 32'd1);
            step();
        end
        check("b2b_pulses", 32'(pulses), 32'd1);
        check("b2b_second_done", 32'(concluido_msb), 32'd1);
        habilitar = 1'b0;
        step();

        // Asynchronous reset after three bits
        carregar  = 1'b1;
        dado      = 8'hFF;
        habilitar = 1'b1;
        step();
        carregar = 1'b0;
        repeat (3) step();
        check("pre_reset_busy", 32'(ocupado_msb), 32'd1);
        check("pre_reset_cnt", 32'(contagem_msb), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_bit", 32'(bit_msb), 32'd0);
        check("async_busy", 32'(ocupado_msb), 32'd0);
        check("async_cnt", 32'(contagem_msb), 32'd0);
        check("async_done", 32'(concluido_msb), 32'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (concluido_msb) pulses++;
        end
        check("reset_no_pulse", 32'(pulses), 32'd0);
        check("reset_stays_idle", 32'(ocupado_msb), 32'd0);

        // LSB-first instance, word 00000001
        carregar  = 1'b1;
        dado      = 8'b0000_0001;
        habilitar = 1'b1;
        step();
        carregar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_bit", 32'(bit_lsb), 32'(i == 0));
            check("lsb_cnt", 32'(contagem_lsb), 32'(i));
            step();
        end
        check("lsb_done", 32'(concluido_lsb), 32'd1);
        check("lsb_busy", 32'(ocupado_lsb), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
